lza_seq_64: RTL and testbench

LZA_SEQ_64 -- requirements
Module: lza_seq_64

---
 rtl/lza_seq_64.sv | 133 +++++++++++++
 tb/tb_lza_seq_64.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lza_seq_64.sv
// lza_seq_64: sequential 64-bit leading-zero counter.
// One shared 16-bit leading-zero counter is reused over the four 16-bit
// chunks of the operand, most significant chunk first. The scan stops
// early at the first chunk that holds a set bit.
// Optional feature: define LZA_SEQ_NORM_EN to also produce the normalized
// operand (operand shifted left by the leading-zero count) on out_norm.
// Without the macro, out_norm is tied to zero and no shifter is built.

module lza_seq_64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_count,
    output logic        out_zero,
    output logic [63:0] out_norm,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] operand;
    logic [1:0]  idx;
    logic [6:0]  acc;
    logic [15:0] chunk;
    logic [4:0]  cnt;
    logic [6:0]  sum;
    logic        last;

    // Select the chunk currently being scanned, MSB chunk at idx=3
    always_comb begin
        chunk = operand[{idx, 4'b0000} +: 16];
    end

    // Shared 16-bit leading-zero counter; 16 when the chunk is all zero
    always_comb begin
        cnt = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (chunk[i]) begin
                cnt = 5'(15 - i);
            end
        end
    end

    // Running total and the decision whether this chunk ends the scan
    always_comb begin
        sum  = acc + {2'b00, cnt};
        last = !cnt[4] || (idx == 2'd0);
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_count <= 7'd0;
            out_zero  <= 1'b0;
            operand   <= 64'd0;
            idx       <= 2'd3;
            acc       <= 7'd0;
        end else if (clr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= 2'd3;
            acc       <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand  <= in_data;
                        idx      <= 2'd3;
                        acc      <= 7'd0;
                        state    <= SCAN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last) begin
                        out_count <= sum;
                        out_zero  <= (sum == 7'd64);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc <= acc + 7'd16;
                        idx <= idx - 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LZA_SEQ_NORM_EN
    // Capture the normalized operand in the same edge that finishes the scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_norm <= 64'd0;
        end else if (!clr && (state == SCAN) && last) begin
            out_norm <= operand << sum;
        end
    end
`else
    assign out_norm = 64'd0;
`endif

endmodule

// File: tb/tb_lza_seq_64.sv
// tb_lza_seq_64: self-checking bench for lza_seq_64.
// A latency/count model derived from the operand value is checked against
// the DUT on every cycle; directed vectors pin hand-computed results.

module tb_lza_seq_64;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_count;
    logic        out_zero;
    logic [63:0] out_norm;
    logic        busy;

    int checks = 0;
    int failures = 0;

    bit          mActive = 1'b0;
    int          mAge = 0;
    int          mLat = 0;
    logic [63:0] mOp = 64'd0;

    lza_seq_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .out_norm  (out_norm),
        .busy      (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference leading-zero count, scanning bit by bit from the MSB
    function automatic int refLzc(input logic [63:0] d);
        for (int i = 63; i >= 0; i--) begin
            if (d[i]) return 63 - i;
        end
        return 64;
    endfunction

    // Cycles from accept to result: one plus the number of chunks examined
    function automatic int latOf(input logic [63:0] d);
        int c;
        c = refLzc(d);
        if (c >= 48) return 5;
        return 2 + c / 16;
    endfunction

    function automatic logic [63:0] expNorm(input logic [63:0] d);
`ifdef LZA_SEQ_NORM_EN
        int c;
        c = refLzc(d);
        if (c == 64) return 64'd0;
        return d << c;
`else
        return 64'd0 & d;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Compare process: checks outputs every cycle, then advances the model
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
            checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_out_count", 64'(out_count), 64'd0);
            checkOutput("rst_out_zero", 64'(out_zero), 64'd0);
            checkOutput("rst_out_norm", out_norm, 64'd0);
            mActive = 1'b0;
        end else begin
            checkOutput("mon_in_ready", 64'(in_ready), 64'(!mActive));
            checkOutput("mon_busy", 64'(busy), 64'(mActive));
            checkOutput("mon_out_valid", 64'(out_valid), 64'(mActive && (mAge >= mLat)));
            if (mActive && (mAge >= mLat)) begin
                checkOutput("mon_out_count", 64'(out_count), 64'(refLzc(mOp)));
                checkOutput("mon_out_zero", 64'(out_zero), 64'(mOp == 64'd0));
                checkOutput("mon_out_norm", out_norm, expNorm(mOp));
            end
`ifndef LZA_SEQ_NORM_EN
            checkOutput("mon_norm_tied", out_norm, 64'd0);
`endif
            if (clr) begin
                mActive = 1'b0;
            end else if (!mActive) begin
                if (in_valid) begin
                    mActive = 1'b1;
                    mOp     = in_data;
                    mAge    = 1;
                    mLat    = latOf(in_data);
                end
            end else if (mAge >= mLat) begin
                if (out_ready) mActive = 1'b0;
            end else begin
                mAge++;
            end
        end
    end

    // Offer one operand; returns just after the accepting edge
    task automatic applyStimulus(input logic [63:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("offer_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept until out_valid rises (bounded)
    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic takeResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("take_in_ready", 64'(in_ready), 64'd1);
        checkOutput("take_out_valid", 64'(out_valid), 64'd0);
    endtask

    // Directed scenarios followed by a random regression
    initial begin
        int lat;
        int n;
        logic [63:0] r;
        logic [63:0] norm1;

`ifdef LZA_SEQ_NORM_EN
        norm1 = 64'h8000_0000_0000_0000;
`else
        norm1 = 64'd0;
`endif
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // MSB set: single chunk scanned
        applyStimulus(64'h8000_0000_0000_0000);
        waitResult(lat);
        checkOutput("msb_latency", 64'(lat), 64'd2);
        checkOutput("msb_count", 64'(out_count), 64'd0);
        checkOutput("msb_zero", 64'(out_zero), 64'd0);
        checkOutput("msb_norm", out_norm, norm1);
        takeResult();

        // Set bit in chunk 1: three chunks scanned
        applyStimulus(64'h0000_0000_0001_0000);
        waitResult(lat);
        checkOutput("c47_latency", 64'(lat), 64'd4);
        checkOutput("c47_count", 64'(out_count), 64'd47);
        checkOutput("c47_zero", 64'(out_zero), 64'd0);
        checkOutput("c47_norm", out_norm, norm1);
        takeResult();

        // All-zero operand: every chunk scanned
        applyStimulus(64'd0);
        waitResult(lat);
        checkOutput("zero_latency", 64'(lat), 64'd5);
        checkOutput("zero_count", 64'(out_count), 64'd64);
        checkOutput("zero_zero", 64'(out_zero), 64'd1);
        checkOutput("zero_norm", out_norm, 64'd0);
        takeResult();

        // Output back-pressure: result must hold for ten cycles
        applyStimulus(64'h0000_00F0_0000_0000);
        waitResult(lat);
        checkOutput("hold_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_count", 64'(out_count), 64'd24);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        takeResult();

        // Abort during the second scan cycle of a zero operand
        applyStimulus(64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_in_ready", 64'(in_ready), 64'd1);
        checkOutput("clr_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("clr_no_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(64'h1);
        waitResult(lat);
        checkOutput("one_latency", 64'(lat), 64'd5);
        checkOutput("one_count", 64'(out_count), 64'd63);
        checkOutput("one_zero", 64'(out_zero), 64'd0);
        checkOutput("one_norm", out_norm, norm1);
        takeResult();

        // Asynchronous reset in the middle of a scan
        applyStimulus(64'h0000_0000_0000_FFFF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_count", 64'(out_count), 64'd0);
        checkOutput("arst_zero", 64'(out_zero), 64'd0);
        checkOutput("arst_norm", out_norm, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(64'h8000_0000_0000_0000);
        waitResult(lat);
        checkOutput("post_rst_latency", 64'(lat), 64'd2);
        checkOutput("post_rst_count", 64'(out_count), 64'd0);
        takeResult();

        // Random regression with stray in_valid and output stalls
        for (int k = 0; k < 10000; k++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: r = 64'd0;
                1: r = 64'd1 << $urandom_range(0, 63);
                2, 3: r = r >> $urandom_range(0, 63);
                default: r = r;
            endcase
            n = 0;
            while (!in_ready && n < 50) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = {$urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) checkOutput("rnd_ready_timeout", 64'(in_ready), 64'd1);
            in_valid  = 1'b1;
            in_data   = r;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("final_in_ready", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
